// File: rtl/ft60x_axi_cmd.sv
// FT60x command decoder: parses WRITE/READ headers from the rx word stream and
// issues single AXI4 INCR bursts, returning read data and a status word on tx.
module ft60x_axi_cmd #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_valid_i,
   input  logic [31:0] rx_data_i,
   output logic        rx_accept_o,
   output logic        tx_valid_o,
   output logic [31:0] tx_data_o,
   input  logic        tx_accept_i,
   output logic        axi_awvalid_o,
   output logic [31:0] axi_awaddr_o,
   output logic [3:0]  axi_awid_o,
   output logic [7:0]  axi_awlen_o,
   output logic [1:0]  axi_awburst_o,
   input  logic        axi_awready_i,
   output logic        axi_wvalid_o,
   output logic [31:0] axi_wdata_o,
   output logic [3:0]  axi_wstrb_o,
   output logic        axi_wlast_o,
   input  logic        axi_wready_i,
   input  logic        axi_bvalid_i,
   input  logic [1:0]  axi_bresp_i,
   input  logic [3:0]  axi_bid_i,
   output logic        axi_bready_o,
   output logic        axi_arvalid_o,
   output logic [31:0] axi_araddr_o,
   output logic [3:0]  axi_arid_o,
   output logic [7:0]  axi_arlen_o,
   output logic [1:0]  axi_arburst_o,
   input  logic        axi_arready_i,
   input  logic        axi_rvalid_i,
   input  logic [31:0] axi_rdata_i,
   input  logic [1:0]  axi_rresp_i,
   input  logic [3:0]  axi_rid_i,
   input  logic        axi_rlast_i,
   output logic        axi_rready_o
);

   localparam logic [7:0] CMD_WR = 8'h01;
   localparam logic [7:0] CMD_RD = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_AW, S_WDATA, S_BRESP, S_AR, S_RDATA, S_STATUS
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d, len_q, len_d, beat_q, beat_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  resp_q, resp_d;

   // IDs are single-outstanding, so the returned IDs carry no information.
   logic unused_ok;
   assign unused_ok = ^{axi_bid_i, axi_rid_i};

   assign axi_awaddr_o  = addr_q;
   assign axi_araddr_o  = addr_q;
   assign axi_awlen_o   = len_q;
   assign axi_arlen_o   = len_q;
   assign axi_awid_o    = AXI_ID;
   assign axi_arid_o    = AXI_ID;
   assign axi_awburst_o = 2'b01;
   assign axi_arburst_o = 2'b01;
   assign axi_wstrb_o   = 4'hF;
   assign axi_wdata_o   = rx_data_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         addr_q  <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         addr_q  <= addr_d;
         resp_q  <= resp_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      len_d         = len_q;
      beat_d        = beat_q;
      addr_d        = addr_q;
      resp_d        = resp_q;
      rx_accept_o   = 1'b0;
      tx_valid_o    = 1'b0;
      tx_data_o     = '0;
      axi_awvalid_o = 1'b0;
      axi_wvalid_o  = 1'b0;
      axi_wlast_o   = 1'b0;
      axi_bready_o  = 1'b0;
      axi_arvalid_o = 1'b0;
      axi_rready_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            rx_accept_o = 1'b1;
            if (rx_valid_i && (rx_data_i[31:24] == CMD_WR || rx_data_i[31:24] == CMD_RD)) begin
               cmd_d   = rx_data_i[31:24];
               len_d   = rx_data_i[7:0];
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            rx_accept_o = 1'b1;
            if (rx_valid_i) begin
               addr_d  = rx_data_i;
               state_d = (cmd_q == CMD_WR) ? S_AW : S_AR;
            end
         end
         S_AW: begin
            axi_awvalid_o = 1'b1;
            if (axi_awready_i) begin
               beat_d  = '0;
               state_d = S_WDATA;
            end
         end
         // Write data flows straight from rx to W; backpressure flows back.
         S_WDATA: begin
            axi_wvalid_o = rx_valid_i;
            rx_accept_o  = axi_wready_i;
            axi_wlast_o  = (beat_q == len_q);
            if (rx_valid_i && axi_wready_i) begin
               beat_d = beat_q + 8'd1;
               if (beat_q == len_q) state_d = S_BRESP;
            end
         end
         S_BRESP: begin
            axi_bready_o = 1'b1;
            if (axi_bvalid_i) begin
               resp_d  = axi_bresp_i;
               state_d = S_STATUS;
            end
         end
         S_AR: begin
            axi_arvalid_o = 1'b1;
            if (axi_arready_i) begin
               resp_d  = '0;
               state_d = S_RDATA;
            end
         end
         S_RDATA: begin
            tx_valid_o   = axi_rvalid_i;
            tx_data_o    = axi_rdata_i;
            axi_rready_o = tx_accept_i;
            if (axi_rvalid_i && tx_accept_i) begin
               resp_d = resp_q | axi_rresp_i;
               if (axi_rlast_i) state_d = S_STATUS;
            end
         end
         S_STATUS: begin
            tx_valid_o = 1'b1;
            tx_data_o  = {cmd_q, 22'd0, resp_q};
            if (tx_accept_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ft60x_axi_cmd.sv
// Randomized scoreboard bench for ft60x_axi_cmd with an AXI slave and FT60x stream models.
module tb_ft60x_axi_cmd;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid_i, rx_accept_o, tx_valid_o, tx_accept_i;
   logic [31:0] rx_data_i, tx_data_o;
   logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rlast, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  awid, wstrb, bid, arid, rid;
   logic [7:0]  awlen, arlen;
   logic [1:0]  awburst, bresp, arburst, rresp;

   always #5 clk = ~clk;

   ft60x_axi_cmd dut (
      .clk_i(clk), .rst_i(rst),
      .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_accept_o(rx_accept_o),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_accept_i(tx_accept_i),
      .axi_awvalid_o(awvalid), .axi_awaddr_o(awaddr), .axi_awid_o(awid), .axi_awlen_o(awlen),
      .axi_awburst_o(awburst), .axi_awready_i(awready),
      .axi_wvalid_o(wvalid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
      .axi_wready_i(wready),
      .axi_bvalid_i(bvalid), .axi_bresp_i(bresp), .axi_bid_i(bid), .axi_bready_o(bready),
      .axi_arvalid_o(arvalid), .axi_araddr_o(araddr), .axi_arid_o(arid), .axi_arlen_o(arlen),
      .axi_arburst_o(arburst), .axi_arready_i(arready),
      .axi_rvalid_i(rvalid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rid_i(rid),
      .axi_rlast_i(rlast), .axi_rready_o(rready)
   );

   int n_chk = 0, n_fail = 0;

   // Stimulus words, expected DUT outputs, and slave-side response data.
   logic [31:0] rx_q[$];
   logic [39:0] exp_aw[$], exp_ar[$];
   logic [32:0] exp_w[$];
   logic [31:0] exp_tx[$];
   logic [1:0]  b_resp_q[$];
   logic [33:0] rd_q[$];

   int rx_pct = 80, w_pct = 100, ar_pct = 70, r_pct = 80, aw_delay = 0, tx_mode = 0;
   int w_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got unexpected event, expected none", name);
   endtask

   // Monitor/scoreboard at negedge; slave and stream drivers at posedge+1.
   initial begin
      int aw_wait, r_left;
      bit b_pend, tx_tog;
      logic [39:0] ea;
      logic [32:0] ew;
      logic [31:0] et;
      aw_wait = 0; r_left = 0; b_pend = 0; tx_tog = 0;
      rx_valid_i = 0; rx_data_i = 0; tx_accept_i = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            aw_wait = 0; r_left = 0; b_pend = 0;
         end else begin
            if (rx_valid_i && rx_accept_o && rx_q.size() > 0) void'(rx_q.pop_front());
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) fail("aw_unexpected");
               else begin
                  ea = exp_aw.pop_front();
                  check("aw_addr_len", {awaddr, awlen}, ea);
               end
               check("aw_burst_id", {awburst, awid}, {2'b01, 4'd0});
               aw_wait = 0;
            end else if (awvalid) aw_wait++;
            if (wvalid && wready) begin
               w_cnt++;
               if (exp_w.size() == 0) fail("w_unexpected");
               else begin
                  ew = exp_w.pop_front();
                  check("w_last_data", {wlast, wdata}, ew);
                  if (wlast) b_pend = 1;
               end
               check("w_strb", wstrb, 4'hF);
            end
            if (bvalid && bready) begin
               b_pend = 0;
               if (b_resp_q.size() > 0) void'(b_resp_q.pop_front());
            end
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) fail("ar_unexpected");
               else begin
                  ea = exp_ar.pop_front();
                  check("ar_addr_len", {araddr, arlen}, ea);
               end
               check("ar_burst_id", {arburst, arid}, {2'b01, 4'd0});
               r_left = int'(arlen) + 1;
            end
            if (rvalid)
               check("r_passthru", {rready, tx_valid_o, tx_data_o}, {tx_accept_i, 1'b1, rdata});
            if (rvalid && rready) begin
               r_left--;
               if (rd_q.size() > 0) void'(rd_q.pop_front());
            end
            if (tx_valid_o && tx_accept_i) begin
               if (exp_tx.size() == 0) fail("tx_unexpected");
               else begin
                  et = exp_tx.pop_front();
                  check("tx_word", tx_data_o, et);
               end
            end
         end
         @(posedge clk);
         #1;
         if (rst) begin
            rx_valid_i = 0; awready = 0; wready = 0; bvalid = 0;
            arready = 0; rvalid = 0; rlast = 0; tx_accept_i = 0;
         end else begin
            rx_valid_i = (rx_q.size() > 0) && ($urandom_range(99) < rx_pct);
            rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : $urandom;
            awready    = (aw_wait >= aw_delay);
            wready     = ($urandom_range(99) < w_pct);
            bvalid     = b_pend;
            bresp      = (b_resp_q.size() > 0) ? b_resp_q[0] : 2'b00;
            bid        = 4'($urandom);
            arready    = ($urandom_range(99) < ar_pct);
            rid        = 4'($urandom);
            // An R beat once offered stays offered until taken.
            if (r_left > 0 && rd_q.size() > 0 && ((rvalid && !rready) || $urandom_range(99) < r_pct)) begin
               rvalid = 1; rdata = rd_q[0][31:0]; rresp = rd_q[0][33:32]; rlast = (r_left == 1);
            end else begin
               rvalid = 0; rlast = 0; rdata = $urandom;
            end
            tx_tog = ~tx_tog;
            tx_accept_i = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? tx_tog : 1'($urandom);
         end
      end
   end

   task automatic send_write(input logic [31:0] addr, input int len, input logic [1:0] br,
                             input bit fixed, input logic [31:0] fdata);
      logic [31:0] d;
      rx_q.push_back({8'h01, 16'($urandom), 8'(len)});
      rx_q.push_back(addr);
      exp_aw.push_back({addr, 8'(len)});
      for (int i = 0; i <= len; i++) begin
         d = fixed ? fdata : $urandom;
         rx_q.push_back(d);
         exp_w.push_back({(i == len), d});
      end
      b_resp_q.push_back(br);
      exp_tx.push_back({8'h01, 22'd0, br});
   endtask

   // err_beat < 0 draws a random response per beat.
   task automatic send_read(input logic [31:0] addr, input int len, input int err_beat,
                            input logic [1:0] err_resp);
      logic [31:0] d;
      logic [1:0]  r, acc;
      acc = 2'b00;
      rx_q.push_back({8'h02, 16'($urandom), 8'(len)});
      rx_q.push_back(addr);
      exp_ar.push_back({addr, 8'(len)});
      for (int i = 0; i <= len; i++) begin
         d = $urandom;
         if (err_beat < 0) r = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
         else r = (i == err_beat) ? err_resp : 2'b00;
         acc = acc | r;
         rd_q.push_back({r, d});
         exp_tx.push_back(d);
      end
      exp_tx.push_back({8'h02, 22'd0, acc});
   endtask

   task automatic wait_done(input string name);
      int t;
      for (t = 0; t < 5000; t++) begin
         @(posedge clk);
         #2;
         if (rx_q.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
             exp_ar.size() == 0 && exp_tx.size() == 0) break;
      end
      if (t == 5000) fail({name, "_timeout"});
      @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {rx_accept_o, awvalid, wvalid, bready, arvalid, rready, tx_valid_o},
            7'b1000000);
      @(posedge clk);
      #2 rst = 1'b0;

      send_write(32'h0000_1000, 0, 2'b00, 1, 32'hDEAD_BEEF);
      wait_done("write_len0");

      aw_delay = 5; w_pct = 60;
      send_write(32'h0000_3000, 3, 2'b10, 0, 32'h0);
      wait_done("write_len3");
      aw_delay = 0; w_pct = 100;

      tx_mode = 1;
      send_read(32'h0000_2000, 7, 2, 2'b10);
      wait_done("read_len7");
      tx_mode = 0;

      rx_q.push_back({8'h7F, 24'($urandom)});
      send_read(32'h0000_4000, 2, -1, 2'b00);
      wait_done("unknown_cmd");

      // Async reset in the middle of a write burst, second beat pending.
      rx_pct = 100;
      base = w_cnt;
      send_write(32'h0000_5000, 3, 2'b00, 0, 32'h0);
      for (int t = 0; t < 200 && w_cnt == base; t++) begin
         @(posedge clk);
         #2;
      end
      check("reset_reached_beat2", w_cnt - base, 1);
      rst = 1'b1;
      rx_q.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete();
      exp_tx.delete(); b_resp_q.delete(); rd_q.delete();
      @(negedge clk);
      check("midcmd_reset", {rx_accept_o, awvalid, wvalid, bready, arvalid, rready, tx_valid_o},
            7'b1000000);
      @(posedge clk);
      #2 rst = 1'b0;
      rx_pct = 80;
      send_write(32'h0000_6000, 1, 2'b01, 0, 32'h0);
      wait_done("write_after_reset");

      send_write(32'h0001_0000, 255, 2'b00, 0, 32'h0);
      wait_done("write_len255");

      for (int k = 0; k < 8; k++) begin
         w_pct = $urandom_range(40, 100); ar_pct = $urandom_range(30, 100);
         r_pct = $urandom_range(30, 100); rx_pct = $urandom_range(40, 100);
         aw_delay = $urandom_range(0, 3); tx_mode = $urandom_range(0, 2);
         if ($urandom_range(1) == 1) send_write($urandom, $urandom_range(0, 15), 2'($urandom), 0, 32'h0);
         else send_read($urandom, $urandom_range(0, 15), -1, 2'b00);
         wait_done("random_cmd");
      end

      check("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_tx.size(), 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/ft60x_axi_cmd.md
# ft60x_axi_cmd

Command decoder and AXI4 bus master front end for the FT60x bridge. It consumes the 32-bit word stream received from the FT60x FIFO interface and parses command headers. It issues AXI4 INCR bursts on its master port, which feeds the AXI retime stage. Read data and a per-command status word are returned on a 32-bit transmit stream back towards the FT60x.

## Interface
- AXI_ID, default 4'd0: value driven on axi_awid_o and axi_arid_o.
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- rx_valid_i / rx_data_i / rx_accept_o  in/in/out  1/32/1  received command stream; a word transfers when valid & accept.
- tx_valid_o / tx_data_o / tx_accept_i  out/out/in  1/32/1  response stream; a word transfers when valid & accept.
- axi_awvalid_o, axi_awaddr_o[31:0], axi_awid_o[3:0], axi_awlen_o[7:0], axi_awburst_o[1:0]  out: write address channel.
- axi_awready_i  in  1: write address channel ready.
- axi_wvalid_o, axi_wdata_o[31:0], axi_wstrb_o[3:0], axi_wlast_o  out: write data channel.
- axi_wready_i  in  1: write data channel ready.
- axi_bvalid_i, axi_bresp_i[1:0], axi_bid_i[3:0]  in: write response; bid is ignored.
- axi_bready_o  out  1: write response ready.
- axi_arvalid_o, axi_araddr_o[31:0], axi_arid_o[3:0], axi_arlen_o[7:0], axi_arburst_o[1:0]  out: read address channel.
- axi_arready_i  in  1: read address channel ready.
- axi_rvalid_i, axi_rdata_i[31:0], axi_rresp_i[1:0], axi_rid_i[3:0], axi_rlast_i  in: read data; rid is ignored.
- axi_rready_o  out  1: read data ready.

## Operation
- Header word: [31:24] cmd, [7:0] len (beats-1, range 0..255). Bits [23:8] are ignored.
- Supported cmd values: 0x01 = WRITE, 0x02 = READ. Any other cmd consumes the header only and returns to IDLE with no response.
- Word 2 is the byte address. A WRITE is followed by len+1 data words. A READ has no further words.
- awburst/arburst are fixed at 2'b01 (INCR). wstrb is fixed at 4'hF. awlen/arlen = len. Address and len are registered and held until the command ends.
- States and transitions:
  - IDLE: rx_accept_o=1. A header is captured and the next state is ADDR for cmd 0x01/0x02; otherwise stay in IDLE.
  - ADDR: rx_accept_o=1. On transfer, capture the address; go to AW for WRITE, AR for READ.
  - AW: axi_awvalid_o=1 and rx_accept_o=0. On awready, clear the beat counter and go to WDATA.
  - WDATA: pass-through, with wvalid=rx_valid_i, wdata=rx_data_i, rx_accept_o=axi_wready_i. wlast=(beat==len). The beat counter increments on each W transfer. A transfer with wlast goes to BRESP.
  - BRESP: bready=1. On bvalid, capture bresp and go to STATUS.
  - AR: arvalid=1. On arready, clear the response accumulator and go to RDATA.
  - RDATA: pass-through, with tx_valid=rvalid, tx_data=rdata, rready=tx_accept_i. The accumulator ORs in rresp on each R transfer. A transfer with rlast goes to STATUS.
  - STATUS: tx_valid_o=1. tx_data_o = {cmd[7:0], 22'b0, resp[1:0]}, where resp = bresp (WRITE) or the OR-accumulated rresp (READ). On tx_accept_i, go to IDLE.
- The beat counter is 8 bits and never wraps within a command, since len ≤ 255. Burst length comes from rlast, not from the counter.
- Only one command is outstanding at a time. No header is accepted until STATUS completes.

## Timing
- Reset values:
  - State = IDLE.
  - rx_accept_o=1.
  - All axi_*valid_o, axi_bready_o, axi_rready_o and tx_valid_o = 0.
  - Registered address, len, cmd, beat counter and resp = 0.
- Latency:
  - Header accepted in cycle N; address at N+1 at the earliest.
  - awvalid/arvalid are asserted from N+2 and held until ready; valid never drops without a handshake.
  - W and R data paths are combinational, with zero added latency.
  - The status word appears the cycle after the B handshake, or after the rlast handshake.
- Stalls: rx_valid_i low in IDLE, ADDR or WDATA, or tx_accept_i low in RDATA or STATUS, holds the current state with no loss.
- Async reset mid-command returns to IDLE immediately and drops all valids. Partially issued AXI bursts are not completed.

## Test plan
- WRITE len=0: 0x01000000, 0x00001000, 0xDEADBEEF -> one AW (addr 0x1000, len 0, burst 1), one W with wlast=1 and wstrb=F, bresp=0 -> tx word 0x01000000.
- WRITE len=3 with random wready and awready delayed 5 cycles -> 4 W beats in order, wlast only on beat 4; bresp=2'b10 -> status 0x01000002.
- READ len=7 at 0x2000, tx_accept_i toggling -> AR (len 7), 8 rdata words forwarded unchanged, rready mirrors tx_accept. rresp=2'b10 on beat 3 -> status 0x02000002.
- Unknown cmd 0x7F header, then a valid READ header -> the 0x7F word is dropped with no AXI activity; the READ proceeds normally.
- rst_i asserted during WDATA beat 2 of a len=3 write -> next cycle all valids 0, rx_accept_o=1; a following WRITE completes correctly.
- WRITE len=255 -> 256 W beats, wlast only on beat 256; the counter does not wrap early.
